// File: rtl/main_bus_arbiter.sv
// Round-robin owner arbitration for the shared main memory bus.
// Optional WAIT-phase abort counter enabled by defining MBA_TIMEOUT_EN.
module main_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      resetH,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic                      bus_done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      bus_start,
  output logic                      bus_rw,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               start_q, start_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic [IDW-1:0]     ptr_q, ptr_d;

  logic               any_req;
  logic [IDW-1:0]     win;
  logic               win_rw;
  logic [ADDR_W-1:0]  win_addr;
  logic               tmo_hit;

  // First set request at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    any_req  = 1'b0;
    win      = '0;
    win_rw   = 1'b0;
    win_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req  = 1'b1;
        win      = IDW'(idx);
        win_rw   = req_rw[idx];
        win_addr = req_addr[idx*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef MBA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == S_WAIT) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resetH) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_GRANT;
      S_GRANT: state_d = bus_done ? S_IDLE : S_WAIT;
      S_WAIT:  if (bus_done || tmo_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    start_d = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = NUM_REQ'(1) << win;
          start_d = 1'b1;
          rw_d    = win_rw;
          addr_d  = win_addr;
          owner_d = win;
          busy_d  = 1'b1;
        end
      end
      S_GRANT, S_WAIT: begin
        if (bus_done || tmo_hit) begin
          grant_d = '0;
          busy_d  = 1'b0;
          tmo_d   = ~bus_done;
          ptr_d   = (owner_q == IDW'(NUM_REQ - 1)) ?
                    '0 : owner_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign bus_start   = start_q;
  assign bus_rw      = rw_q;
  assign bus_addr    = addr_q;
  assign owner_id    = owner_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Bench for main_bus_arbiter: directed steps plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_main_bus_arbiter;

  localparam int N = 4;
  localparam int AW = 16;
`ifdef MBA_TIMEOUT_EN
  localparam int TMO = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO = 64;
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetH;
  logic [N-1:0]    req;
  logic [N-1:0]    req_rw;
  logic [N*AW-1:0] req_addr;
  logic            bus_done;
  logic [N-1:0]    grant;
  logic            bus_start;
  logic            bus_rw;
  logic [AW-1:0]   bus_addr;
  logic [1:0]      owner_id;
  logic            busy;
  logic            timeout_err;

  main_bus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetH(resetH), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .bus_done(bus_done), .grant(grant),
    .bus_start(bus_start), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .owner_id(owner_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, and for how long.
  bit          m_busy, m_start, m_tmo, m_rw, m_clean, m_ingrant;
  int          m_owner, m_ptr, m_waits;
  logic [AW-1:0] m_addr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_release();
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % N;
  endfunction

  function automatic void m_edge();
    m_start = 1'b0;
    m_tmo   = 1'b0;
    if (resetH) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_rw = 0;
      m_addr = '0; m_clean = 1; m_ingrant = 0; m_waits = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!m_busy && req[i]) begin
          m_busy = 1; m_start = 1; m_owner = i;
          m_rw = req_rw[i]; m_addr = req_addr[i*AW +: AW];
          m_ingrant = 1; m_clean = 0;
        end
      end
    end else if (bus_done) begin
      m_release();
    end else if (m_ingrant) begin
      m_ingrant = 0;
      m_waits = 0;
    end else begin
      m_waits++;
      if (TMO_EN && m_waits == TMO) begin
        m_tmo = 1;
        m_release();
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("busy", busy, m_busy);
    chk("bus_start", bus_start, m_start);
    chk("timeout_err", timeout_err, m_tmo);
    if (m_busy || m_clean) begin
      chk("owner_id", owner_id, m_owner);
      chk("bus_rw", bus_rw, m_rw);
      chk("bus_addr", bus_addr, m_addr);
    end
  endtask

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (bus_start === 1'b1) ok = 1;
    end
    chk("start_seen", ok, 1);
  endtask

  task automatic done_pulse();
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
  endtask

  task automatic do_reset();
    resetH = 1'b1;
    step();
    resetH = 1'b0;
  endtask

  initial begin
    int tmo_seen;
    bit dropped;
    resetH = 1'b1; req = 4'b1111; req_rw = '0;
    req_addr = '0; bus_done = 1'b0;

    // 1: reset held with all requests pending
    step();
    step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    resetH = 1'b0;
    req = '0;
    step();

    // 2: single read from requester 2
    req_rw = 4'b0100;
    req_addr[2*AW +: AW] = 16'h3A5C;
    req = 4'b0100;
    step();
    chk("t2_grant", grant, 4'b0100);
    chk("t2_addr", bus_addr, 16'h3A5C);
    chk("t2_rw", bus_rw, 1'b1);
    req = '0;
    repeat (4) step();
    chk("t2_start_low", bus_start, 1'b0);
    done_pulse();
    chk("t2_release", grant, 4'b0000);
    step();

    // 3: fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(16'h1000 * i + 7);
    req_rw = 4'b1010;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start();
      chk("t3_owner", owner_id, g % N);
      step();
      step();
      done_pulse();
      chk("t3_gap", grant, 4'b0000);
    end

    // 4: pointer wraps past requester 3
    req = 4'b1000;
    wait_start();
    chk("t4_own3", grant, 4'b1000);
    req = '0;
    done_pulse();
    req = 4'b1001;
    wait_start();
    chk("t4_wrap", grant, 4'b0001);
    req = '0;
    done_pulse();
    step();

    // 5: reset in the middle of WAIT
    do_reset();
    req = 4'b0010;
    wait_start();
    req = '0;
    step();
    step();
    chk("t5_wait_own", grant, 4'b0010);
    do_reset();
    chk("t5_rst_grant", grant, 4'b0000);
    chk("t5_rst_addr", bus_addr, 16'h0000);
    req = 4'b1000;
    wait_start();
    chk("t5_after", grant, 4'b1000);
    req = '0;
    done_pulse();

    // 6: no done from memory side for a long stretch
    do_reset();
    req = 4'b0011;
    wait_start();
    tmo_seen = 0;
    dropped = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      if (timeout_err === 1'b1) tmo_seen++;
      if (grant === 4'b0000) dropped = 1;
    end
`ifdef MBA_TIMEOUT_EN
    chk("t6_tmo_seen", tmo_seen != 0, 1);
`else
    chk("t6_no_tmo", tmo_seen, 0);
    chk("t6_held", dropped, 0);
`endif
    req = '0;
    done_pulse();
    step();

    // 7: random traffic
    for (int i = 0; i < 400; i++) begin
      resetH   = ($urandom_range(0, 59) == 0);
      req      = N'($urandom);
      req_rw   = N'($urandom);
      req_addr = {$urandom, $urandom};
      bus_done = ($urandom_range(0, 3) == 0);
      step();
    end
    resetH = 1'b0;
    req = '0;
    bus_done = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
